sdram_cpu_port: RTL and testbench

//  Chipset-side initiator for the 16-bit SDRAM controller. Owns the 8-slot

---
 rtl/sdram_pkg.sv | 22 ++
 rtl/sdram_slot_timer.sv | 46 ++++
 rtl/sdram_cpu_port.sv | 172 +++++++++++++++++
 tb/tb_sdram_cpu_port.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - slot constants, port state encoding and byte-strobe helper
package sdram_pkg;

  // Slot phases seen by the controller on sdt
  localparam logic [2:0] STATE_CMD_START   = 3'd0;
  localparam logic [2:0] STATE_CMD_CONT    = 3'd2;
  localparam logic [2:0] STATE_LAST        = 3'd7;
  localparam logic [2:0] READ_SLOT_DEFAULT = 3'd5;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_PEND,
    ST_ACCESS
  } port_state_e;

  // Odd byte addresses live in the low half of the 16-bit word
  function automatic logic [1:0] byte_ds(input logic a0);
    return a0 ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/sdram_slot_timer.sv
// rtl/sdram_slot_timer.sv - free-running slot phase counter with init countdown
module sdram_slot_timer
  import sdram_pkg::*;
#(
  parameter logic [2:0] READ_SLOT  = READ_SLOT_DEFAULT,
  parameter int         INIT_SLOTS = 32
) (
  input  logic       clk_hi,
  input  logic       rst_n,
  output logic [2:0] sdt,
  output logic       boundary,
  output logic       read_strobe,
  output logic       init_last
);

  localparam int IW = $clog2(INIT_SLOTS + 1);

  logic [2:0]    sdt_q, sdt_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;

  assign sdt         = sdt_q;
  assign boundary    = (sdt_q == STATE_LAST);
  assign read_strobe = (sdt_q == READ_SLOT);
  assign init_last   = boundary && (init_cnt_q == IW'(INIT_SLOTS - 1));

  // Phase advances every clock; init count steps once per slot and saturates
  always_comb begin
    sdt_d      = sdt_q + 3'd1;
    init_cnt_d = init_cnt_q;
    if (boundary && (init_cnt_q != IW'(INIT_SLOTS))) begin
      init_cnt_d = init_cnt_q + IW'(1);
    end
  end

  // Phase and init count registers
  always_ff @(posedge clk_hi) begin
    if (!rst_n) begin
      sdt_q      <= 3'd0;
      init_cnt_q <= '0;
    end else begin
      sdt_q      <= sdt_d;
      init_cnt_q <= init_cnt_d;
    end
  end

endmodule

// File: rtl/sdram_cpu_port.sv
// rtl/sdram_cpu_port.sv - CPU byte-request port issuing one-word SDRAM controller slots
module sdram_cpu_port
  import sdram_pkg::*;
#(
  parameter logic [2:0] READ_SLOT   = READ_SLOT_DEFAULT,
  parameter int         REFRESH_MAX = 4,
  parameter int         INIT_SLOTS  = 32
) (
  input  logic        clk_hi,
  input  logic        rst_n,
  output logic [2:0]  sdt,
  output logic        mem_init,
  output logic [23:0] mem_addr,
  output logic [1:0]  mem_ds,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  output logic        mem_oe,
  output logic        mem_we,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [24:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata
);

  localparam int RW = $clog2(REFRESH_MAX + 1);

  port_state_e   state_q, state_d;
  logic [24:0]   pend_addr_q, pend_addr_d;
  logic          pend_we_q, pend_we_d;
  logic [7:0]    pend_wdata_q, pend_wdata_d;
  logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [23:0]   mem_addr_q, mem_addr_d;
  logic [1:0]    mem_ds_q, mem_ds_d;
  logic [15:0]   mem_din_q, mem_din_d;
  logic          mem_oe_q, mem_oe_d;
  logic          mem_we_q, mem_we_d;
  logic          mem_init_q, mem_init_d;
  logic          cpu_ready_q, cpu_ready_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [7:0]    cpu_rdata_q, cpu_rdata_d;

  logic boundary, read_strobe, init_last, pend_now;

  sdram_slot_timer #(
    .READ_SLOT  (READ_SLOT),
    .INIT_SLOTS (INIT_SLOTS)
  ) u_timer (
    .clk_hi      (clk_hi),
    .rst_n       (rst_n),
    .sdt         (sdt),
    .boundary    (boundary),
    .read_strobe (read_strobe),
    .init_last   (init_last)
  );

  assign mem_init  = mem_init_q;
  assign mem_addr  = mem_addr_q;
  assign mem_ds    = mem_ds_q;
  assign mem_din   = mem_din_q;
  assign mem_oe    = mem_oe_q;
  assign mem_we    = mem_we_q;
  assign cpu_ready = cpu_ready_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;

  // Port FSM: accept a byte request, issue it at the next slot boundary
  // (same edge if the request lands on a boundary), complete at the read slot.
  // A boundary with no request, or one forced after REFRESH_MAX accesses,
  // stays idle so the controller can refresh.
  always_comb begin
    state_d       = state_q;
    pend_addr_d   = pend_addr_q;
    pend_we_d     = pend_we_q;
    pend_wdata_d  = pend_wdata_q;
    refresh_cnt_d = refresh_cnt_q;
    mem_addr_d    = mem_addr_q;
    mem_ds_d      = mem_ds_q;
    mem_din_d     = mem_din_q;
    mem_oe_d      = mem_oe_q;
    mem_we_d      = mem_we_q;
    mem_init_d    = 1'b0;
    cpu_ready_d   = cpu_ready_q;
    cpu_ack_d     = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    pend_now      = (state_q == ST_PEND);

    case (state_q)
      ST_INIT: begin
        if (init_last) begin
          state_d     = ST_IDLE;
          cpu_ready_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (cpu_req) begin
          pend_addr_d  = cpu_addr;
          pend_we_d    = cpu_we;
          pend_wdata_d = cpu_wdata;
          cpu_ready_d  = 1'b0;
          state_d      = ST_PEND;
          pend_now     = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (read_strobe) begin
          if (!pend_we_q) begin
            cpu_rdata_d = pend_addr_q[0] ? mem_dout[7:0] : mem_dout[15:8];
          end
          cpu_ack_d   = 1'b1;
          cpu_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: ;
    endcase

    if (boundary) begin
      if (pend_now && (refresh_cnt_q != RW'(REFRESH_MAX))) begin
        mem_addr_d    = pend_addr_d[24:1];
        mem_ds_d      = byte_ds(pend_addr_d[0]);
        mem_din_d     = {pend_wdata_d, pend_wdata_d};
        mem_oe_d      = ~pend_we_d;
        mem_we_d      = pend_we_d;
        refresh_cnt_d = refresh_cnt_q + RW'(1);
        state_d       = ST_ACCESS;
      end else begin
        mem_oe_d      = 1'b0;
        mem_we_d      = 1'b0;
        refresh_cnt_d = '0;
      end
    end
  end

  // State, pending request and output registers
  always_ff @(posedge clk_hi) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      pend_addr_q   <= '0;
      pend_we_q     <= 1'b0;
      pend_wdata_q  <= '0;
      refresh_cnt_q <= '0;
      mem_addr_q    <= '0;
      mem_ds_q      <= '0;
      mem_din_q     <= '0;
      mem_oe_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_init_q    <= 1'b1;
      cpu_ready_q   <= 1'b0;
      cpu_ack_q     <= 1'b0;
      cpu_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      pend_addr_q   <= pend_addr_d;
      pend_we_q     <= pend_we_d;
      pend_wdata_q  <= pend_wdata_d;
      refresh_cnt_q <= refresh_cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_ds_q      <= mem_ds_d;
      mem_din_q     <= mem_din_d;
      mem_oe_q      <= mem_oe_d;
      mem_we_q      <= mem_we_d;
      mem_init_q    <= mem_init_d;
      cpu_ready_q   <= cpu_ready_d;
      cpu_ack_q     <= cpu_ack_d;
      cpu_rdata_q   <= cpu_rdata_d;
    end
  end

endmodule

// File: tb/tb_sdram_cpu_port.sv
// tb/tb_sdram_cpu_port.sv - directed scoreboard bench for sdram_cpu_port
module tb_sdram_cpu_port;

  typedef struct {
    logic        we;
    logic [24:0] addr;
    logic [7:0]  data;
  } req_t;

  logic        clk_hi = 1'b0;
  logic        rst_n;
  logic [2:0]  sdt;
  logic        mem_init;
  logic [23:0] mem_addr;
  logic [1:0]  mem_ds;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        mem_oe;
  logic        mem_we;
  logic        cpu_req;
  logic        cpu_we;
  logic [24:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;

  int errors = 0;
  int checks = 0;

  req_t       sb[$];
  logic       slot_log[$];
  logic [15:0] sdram_m [256] = '{default: 16'h0000};
  logic [7:0]  ref_b [512]   = '{default: 8'h00};

  always #5 clk_hi = ~clk_hi;

  sdram_cpu_port dut (
    .clk_hi    (clk_hi),
    .rst_n     (rst_n),
    .sdt       (sdt),
    .mem_init  (mem_init),
    .mem_addr  (mem_addr),
    .mem_ds    (mem_ds),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .mem_oe    (mem_oe),
    .mem_we    (mem_we),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata)
  );

  // Controller stand-in: byte-masked write mid-slot, read data while oe is up
  always @(posedge clk_hi) begin
    if (mem_we && sdt == 3'd3) begin
      if (mem_ds[1]) sdram_m[mem_addr[7:0]][15:8] <= mem_din[15:8];
      if (mem_ds[0]) sdram_m[mem_addr[7:0]][7:0]  <= mem_din[7:0];
    end
  end
  assign mem_dout = mem_oe ? sdram_m[mem_addr[7:0]] : 16'h0000;

  // One entry per slot: was a request driven in it
  always @(negedge clk_hi) begin
    if (sdt == 3'd0) slot_log.push_back(mem_oe | mem_we);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string p);
    check({p, "_sdt"},      32'(sdt),       32'd0);
    check({p, "_init"},     32'(mem_init),  32'd1);
    check({p, "_ready"},    32'(cpu_ready), 32'd0);
    check({p, "_ack"},      32'(cpu_ack),   32'd0);
    check({p, "_rdata"},    32'(cpu_rdata), 32'd0);
    check({p, "_oe"},       32'(mem_oe),    32'd0);
    check({p, "_we"},       32'(mem_we),    32'd0);
    check({p, "_addr"},     32'(mem_addr),  32'd0);
    check({p, "_ds"},       32'(mem_ds),    32'd0);
    check({p, "_din"},      32'(mem_din),   32'd0);
  endtask

  task automatic do_req(input logic we, input logic [24:0] a, input logic [7:0] d);
    int   n;
    req_t e;
    n = 0;
    while (!cpu_ready && n < 40) begin
      @(negedge clk_hi);
      n++;
    end
    check("req_ready_wait", 32'(cpu_ready), 32'd1);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    e.we   = we;
    e.addr = a;
    if (we) begin
      ref_b[a[8:0]] = d;
      e.data = d;
    end else begin
      e.data = ref_b[a[8:0]];
    end
    sb.push_back(e);
    @(negedge clk_hi);
    cpu_req = 1'b0;
  endtask

  task automatic wait_ack();
    int   n;
    req_t e;
    n = 0;
    while (!cpu_ack && n < 40) begin
      @(negedge clk_hi);
      n++;
    end
    check("ack_timeout", 32'(cpu_ack), 32'd1);
    e = sb.pop_front();
    check("ack_sdt",  32'(sdt),      32'd6);
    check("mem_addr", 32'(mem_addr), 32'(e.addr[24:1]));
    check("mem_ds",   32'(mem_ds),   e.addr[0] ? 32'd1 : 32'd2);
    check("mem_we",   32'(mem_we),   32'(e.we));
    check("mem_oe",   32'(mem_oe),   32'(!e.we));
    if (e.we) check("mem_din", 32'(mem_din), 32'({e.data, e.data}));
    else      check("rdata",   32'(cpu_rdata), 32'(e.data));
  endtask

  initial begin
    int   s0, s1, f, ones, bad, n, extra;
    logic [24:0] a;
    logic [24:0] last_wr;

    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    repeat (3) @(negedge clk_hi);
    check_reset("rst");

    // Reset release: init held one clock, sdt counts, ready after 32 slots
    rst_n = 1'b1;
    check("init_before_edge", 32'(mem_init), 32'd1);
    bad = 0;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk_hi);
      if (k == 1) check("init_dropped", 32'(mem_init), 32'd0);
      if (k <= 9) check($sformatf("sdt_seq%0d", k), 32'(sdt), 32'(k % 8));
      if (k < 256 && cpu_ready) bad++;
    end
    check("ready_early", 32'(bad), 32'd0);
    check("ready_after_init", 32'(cpu_ready), 32'd1);

    // Odd byte write then readback
    do_req(1'b1, 25'h000101, 8'hA5);
    wait_ack();
    do_req(1'b0, 25'h000101, 8'h00);
    wait_ack();

    // Even byte write, readback with ack width, odd byte untouched
    do_req(1'b1, 25'h000100, 8'h3C);
    wait_ack();
    do_req(1'b0, 25'h000100, 8'h00);
    wait_ack();
    @(negedge clk_hi);
    check("ack_one_clock", 32'(cpu_ack), 32'd0);
    check("ready_after_ack", 32'(cpu_ready), 32'd1);
    check("rdata_hold", 32'(cpu_rdata), 32'h3C);
    do_req(1'b0, 25'h000101, 8'h00);
    wait_ack();

    // Back-to-back requests: 4 access slots then one idle slot, repeating
    repeat (16) @(negedge clk_hi);
    s0 = slot_log.size();
    last_wr = 25'h40;
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) begin
        a = 25'h40 + 25'(3 * i);
        last_wr = a;
        do_req(1'b1, a, 8'h10 + 8'(i));
      end else begin
        do_req(1'b0, last_wr, 8'h00);
      end
      wait_ack();
    end
    s1 = slot_log.size();
    f = -1;
    ones = 0;
    for (int j = s0; j < s1; j++) begin
      if (slot_log[j]) begin
        ones++;
        if (f < 0) f = j;
      end
    end
    check("burst_slots", 32'(ones), 32'd12);
    bad = 0;
    for (int j = 0; j < 14; j++) begin
      if (f < 0 || f + j >= s1 || slot_log[f + j] !== ((j % 5) != 4)) bad++;
    end
    check("burst_pattern", 32'(bad), 32'd0);

    // Request while busy is dropped
    repeat (16) @(negedge clk_hi);
    s0 = slot_log.size();
    do_req(1'b0, 25'h000101, 8'h00);
    check("busy_not_ready", 32'(cpu_ready), 32'd0);
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 25'h0001FF;
    cpu_wdata = 8'h77;
    @(negedge clk_hi);
    cpu_req = 1'b0;
    wait_ack();
    extra = 0;
    repeat (24) begin
      @(negedge clk_hi);
      if (cpu_ack) extra++;
    end
    check("ignored_no_ack", 32'(extra), 32'd0);
    ones = 0;
    for (int j = s0; j < slot_log.size(); j++) if (slot_log[j]) ones++;
    check("ignored_no_slot", 32'(ones), 32'd1);
    do_req(1'b0, 25'h0001FF, 8'h00);
    wait_ack();

    // Reset in the middle of a read: no ack, full re-init
    do_req(1'b0, 25'h000100, 8'h00);
    n = 0;
    while (!(mem_oe && sdt == 3'd3) && n < 40) begin
      @(negedge clk_hi);
      n++;
    end
    check("midread_reached", 32'(mem_oe && sdt == 3'd3), 32'd1);
    rst_n = 1'b0;
    void'(sb.pop_front());
    @(negedge clk_hi);
    check_reset("midrst");
    rst_n = 1'b1;
    n = 0;
    extra = 0;
    while (!cpu_ready && n < 300) begin
      @(negedge clk_hi);
      n++;
      if (cpu_ack) extra++;
    end
    check("reinit_clocks", 32'(n), 32'd256);
    check("reinit_no_ack", 32'(extra), 32'd0);
    do_req(1'b0, 25'h000100, 8'h00);
    wait_ack();
    do_req(1'b0, 25'h000101, 8'h00);
    wait_ack();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
